// File: rtl/cereal_pkg.sv
// Shared definitions for the cereal_tx serial transmitter.
package cereal_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // PARITY parameter values
  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

endpackage

// File: rtl/cereal_tx_if.sv
// Valid/ready word handshake into the transmitter queue.
interface cereal_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/cereal_tx_baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, restartable.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Count up, wrapping at the end of each bit or on an explicit restart
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge sysclk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cereal_tx.sv
// Queued UART transmitter: inline FIFO feeding a start/data/parity/stop FSM.
module cereal_tx
  import cereal_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  cereal_tx_if.slave                    bus,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned BCW = $clog2(DATA_W + 1);
  localparam logic        PAR_INV = (PARITY == PARITY_ODD);

  // Queue storage and bookkeeping
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              in_ready;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  // Transmit FSM
  logic [2:0]        state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              txd_q;
  logic              line;
  logic              tick;
  logic              clear;

  assign in_ready    = (level_q != LW'(FIFO_DEPTH));
  assign bus.in_ready = in_ready;
  assign push        = bus.in_valid && in_ready && !reset;
  assign head        = mem_q[rd_ptr_q];

  // Timer held at zero while idle and restarted on every pop into START
  assign clear = pop || (state_q == ST_IDLE);

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (clear),
    .tick   (tick)
  );

  // Queue storage write
  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  // Queue pointers and occupancy; simultaneous push/pop leaves level unchanged
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Next-state logic; a pop loads the shift register and precomputes parity
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ PAR_INV;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BCW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            if (level_q != '0) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ PAR_INV;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level for the current state
  always_comb begin
    line = 1'b1;
    case (state_q)
      ST_START: line = 1'b0;
      ST_DATA:  line = shift_q[0];
      ST_PAR:   line = par_q;
      default:  line = 1'b1;
    endcase
  end

  // FSM and registered serial output
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= line;
    end
  end

  assign txd        = txd_q;
  assign busy       = (state_q != ST_IDLE) || (level_q != '0);
  assign fifo_level = level_q;
endmodule

// File: tb/tb_cereal_tx.sv
// Directed bench for cereal_tx: four configurations driven from one sequence.
module tb_cereal_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst3;
  logic [7:0] din  [4];
  logic       vld  [4];
  logic       rdy  [4];
  logic       txd  [4];
  logic       busy [4];
  logic [2:0] lvl  [4];

  cereal_tx_if #(.DATA_W(8)) bus0 ();
  cereal_tx_if #(.DATA_W(8)) bus1 ();
  cereal_tx_if #(.DATA_W(8)) bus2 ();
  cereal_tx_if #(.DATA_W(8)) bus3 ();

  assign bus0.in_data = din[0]; assign bus0.in_valid = vld[0]; assign rdy[0] = bus0.in_ready;
  assign bus1.in_data = din[1]; assign bus1.in_valid = vld[1]; assign rdy[1] = bus1.in_ready;
  assign bus2.in_data = din[2]; assign bus2.in_valid = vld[2]; assign rdy[2] = bus2.in_ready;
  assign bus3.in_data = din[3]; assign bus3.in_valid = vld[3]; assign rdy[3] = bus3.in_ready;

  cereal_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .sysclk(clk), .reset(rst), .bus(bus0), .txd(txd[0]), .busy(busy[0]), .fifo_level(lvl[0]));
  cereal_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .sysclk(clk), .reset(rst), .bus(bus1), .txd(txd[1]), .busy(busy[1]), .fifo_level(lvl[1]));
  cereal_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .sysclk(clk), .reset(rst), .bus(bus2), .txd(txd[2]), .busy(busy[2]), .fifo_level(lvl[2]));
  cereal_tx #(.DATA_W(8), .CLKS_PER_BIT(5208), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .sysclk(clk), .reset(rst3), .bus(bus3), .txd(txd[3]), .busy(busy[3]), .fifo_level(lvl[3]));

  int vectors     = 0;
  int miscompares = 0;

  logic       exp_q [$];
  logic [7:0] pend  [$];
  logic       seen  [$];
  int         last_busy_n;
  int         last_rdy_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  // Expected line waveform for one frame, one entry per clock
  task automatic add_frame(input logic [7:0] w, input int parity, input int stops, input int cpb);
    logic b [$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(w[i]);
    if (parity != 0) b.push_back((^w) ^ (parity == 2));
    for (int i = 0; i < stops; i++) b.push_back(1'b1);
    foreach (b[i]) repeat (cpb) exp_q.push_back(b[i]);
  endtask

  // Offer pend words (holding valid until taken) and compare txd every cycle.
  // Sample e is taken just after edge N+e, where edge N is the first offer.
  task automatic run_stream(input int u, input string tag, input int ncyc, input int exp_max_lvl);
    logic acc;
    int   maxl   = 0;
    int   busy_n = 0;
    int   rlow   = 0;
    seen.delete();
    if (pend.size() != 0) begin din[u] = pend[0]; vld[u] = 1'b1; end
    else vld[u] = 1'b0;
    for (int e = 0; e < ncyc; e++) begin
      acc = vld[u] && rdy[u];
      @(negedge clk);
      if (acc) pend.delete(0);
      seen.push_back(txd[u]);
      chk({tag, " txd"}, {31'd0, txd[u]}, {31'd0, (e < exp_q.size()) ? exp_q[e] : 1'b1});
      chk({tag, " ready"}, {31'd0, rdy[u]}, {31'd0, (lvl[u] != 3'd4)});
      if (int'(lvl[u]) > maxl) maxl = int'(lvl[u]);
      if (busy[u]) busy_n++;
      if (!rdy[u]) rlow++;
      if (pend.size() != 0) begin din[u] = pend[0]; vld[u] = 1'b1; end
      else begin vld[u] = 1'b0; din[u] = ~din[u]; end
    end
    last_busy_n  = busy_n;
    last_rdy_low = rlow;
    chk({tag, " max level"}, maxl, exp_max_lvl);
  endtask

  initial begin
    int n;
    int lowc;
    rst = 1'b1; rst3 = 1'b1;
    for (int i = 0; i < 4; i++) begin din[i] = 8'h00; vld[i] = 1'b0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset txd", {31'd0, txd[i]}, 32'd1);
      chk("reset busy", {31'd0, busy[i]}, 32'd0);
      chk("reset level", {29'd0, lvl[i]}, 32'd0);
      chk("reset ready", {31'd0, rdy[i]}, 32'd1);
    end
    rst = 1'b0; rst3 = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x55
    exp_q.delete(); pend.delete();
    pend.push_back(8'h55);
    add_idle(2); add_frame(8'h55, 0, 1, 4);
    run_stream(0, "single55", 50, 1);
    chk("single55 line high before start", {31'd0, seen[1]}, 32'd1);
    chk("single55 start low at N+2", {31'd0, seen[2]}, 32'd0);
    chk("single55 busy cycles", last_busy_n, 41);
    chk("single55 busy after", {31'd0, busy[0]}, 32'd0);

    // Back-to-back four words
    exp_q.delete(); pend.delete();
    pend.push_back(8'hA5); pend.push_back(8'h3C); pend.push_back(8'hFF); pend.push_back(8'h00);
    add_idle(2);
    add_frame(8'hA5, 0, 1, 4); add_frame(8'h3C, 0, 1, 4);
    add_frame(8'hFF, 0, 1, 4); add_frame(8'h00, 0, 1, 4);
    run_stream(0, "b2b", 170, 3);
    chk("b2b ready low cycles", last_rdy_low, 0);
    chk("b2b busy after", {31'd0, busy[0]}, 32'd0);
    chk("b2b level after", {29'd0, lvl[0]}, 32'd0);

    // Overflow: six words offered with valid held
    exp_q.delete(); pend.delete();
    pend.push_back(8'h01); pend.push_back(8'h23); pend.push_back(8'h45);
    pend.push_back(8'h67); pend.push_back(8'h89); pend.push_back(8'hAB);
    add_idle(2);
    add_frame(8'h01, 0, 1, 4); add_frame(8'h23, 0, 1, 4); add_frame(8'h45, 0, 1, 4);
    add_frame(8'h67, 0, 1, 4); add_frame(8'h89, 0, 1, 4); add_frame(8'hAB, 0, 1, 4);
    run_stream(0, "ovf", 260, 4);
    chk("ovf ready low cycles", last_rdy_low, 76);
    chk("ovf all accepted", pend.size(), 0);
    chk("ovf busy after", {31'd0, busy[0]}, 32'd0);

    // Even parity, one stop bit: 44-cycle frame
    exp_q.delete(); pend.delete();
    pend.push_back(8'h07);
    add_idle(2); add_frame(8'h07, 1, 1, 4);
    run_stream(1, "even07", 60, 1);
    chk("even07 parity bit", {31'd0, seen[39]}, 32'd1);
    chk("even07 busy cycles", last_busy_n, 45);

    // Odd parity, two stop bits: 48-cycle frame
    exp_q.delete(); pend.delete();
    pend.push_back(8'h07);
    add_idle(2); add_frame(8'h07, 2, 2, 4);
    run_stream(2, "odd07", 60, 1);
    chk("odd07 parity bit", {31'd0, seen[39]}, 32'd0);
    chk("odd07 busy cycles", last_busy_n, 49);

    // Reset during data bit 3 with two words queued
    exp_q.delete(); pend.delete();
    pend.push_back(8'hC3); pend.push_back(8'h81); pend.push_back(8'h7E);
    add_idle(2); add_frame(8'hC3, 0, 1, 4);
    run_stream(0, "rstmid", 19, 2);
    chk("rstmid queued before reset", {29'd0, lvl[0]}, 32'd2);
    rst = 1'b1; din[0] = 8'h99; vld[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0; vld[0] = 1'b0;
    chk("rstmid txd", {31'd0, txd[0]}, 32'd1);
    chk("rstmid level", {29'd0, lvl[0]}, 32'd0);
    chk("rstmid busy", {31'd0, busy[0]}, 32'd0);
    chk("rstmid ready", {31'd0, rdy[0]}, 32'd1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("rstmid quiet txd", {31'd0, txd[0]}, 32'd1);
      chk("rstmid quiet busy", {31'd0, busy[0]}, 32'd0);
    end

    // Full-rate timing: start bit low for exactly CLKS_PER_BIT cycles
    din[3] = 8'hFF; vld[3] = 1'b1;
    @(negedge clk);
    vld[3] = 1'b0;
    n = 0;
    while (txd[3] === 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("u3 start delay", n, 2);
    lowc = 0;
    while (txd[3] === 1'b0 && lowc < 6000) begin lowc++; @(negedge clk); end
    chk("u3 start bit length", lowc, 5208);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("u3 abort txd", {31'd0, txd[3]}, 32'd1);
    chk("u3 abort busy", {31'd0, busy[3]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
